psa_z80_io_master: RTL and testbench

Z80-side I/O bus initiator for the PSA register block. It turns single register read or write requests into Z80-style I/O cycles on the same bus PSA decodes: `nIORQ`, `nRD`, `nWR`, an 8-bit port address and an 8-bit data bus. It sits in board-level benches and in the MCU-bridge top level as the master that drives PSA ports $00–$0F. It supports configurable setup, strobe and hold timing plus `nWAIT` wait-state insertion.

---
 rtl/psa_z80_io_master.sv | 138 +++++++++++++
 tb/tb_psa_z80_io_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psa_z80_io_master.sv
// Z80-style I/O cycle initiator: turns single read/write requests into
// nIORQ/nRD/nWR cycles with parameterised setup, strobe and hold timing,
// plus nWAIT wait-state insertion.
// Ports: i_CLK/i_RST (sync, active-high); i_REQ_* / o_REQ_READY request
// handshake; o_RSP_VALID/o_RSP_DATA completion; o_nIORQ/o_nRD/o_nWR strobes;
// o_ZA address; o_ZD/o_ZD_OE/i_ZD data bus; i_nWAIT wait request.
module psa_z80_io_master #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_REQ_VALID,
  output logic       o_REQ_READY,
  input  logic       i_REQ_WR,
  input  logic [7:0] i_REQ_ADDR,
  input  logic [7:0] i_REQ_DATA,
  output logic       o_RSP_VALID,
  output logic [7:0] o_RSP_DATA,
  output logic       o_nIORQ,
  output logic       o_nRD,
  output logic       o_nWR,
  output logic [7:0] o_ZA,
  output logic [7:0] o_ZD,
  output logic       o_ZD_OE,
  input  logic [7:0] i_ZD,
  input  logic       i_nWAIT
);

  generate
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
        STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_param
      $error("psa_z80_io_master: timing parameters must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LP_SETUP  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] LP_STROBE = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] LP_HOLD   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_wr;
  logic       w_accept;

  assign o_REQ_READY = (r_state == IDLE) & ~i_RST;
  assign w_accept    = i_REQ_VALID & o_REQ_READY;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = LP_SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = LP_STROBE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      STROBE: begin
        // Counter parks at zero while nWAIT is low: one wait state per cycle.
        if (r_cnt == '0) begin
          if (i_nWAIT) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = LP_HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      o_nIORQ     <= 1'b1;
      o_nRD       <= 1'b1;
      o_nWR       <= 1'b1;
      o_ZA        <= '0;
      o_ZD        <= '0;
      o_ZD_OE     <= 1'b0;
      o_RSP_VALID <= 1'b0;
      o_RSP_DATA  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      o_nIORQ     <= (w_state_nxt != STROBE);
      o_nRD       <= !((w_state_nxt == STROBE) && !r_wr);
      o_nWR       <= !((w_state_nxt == STROBE) && r_wr);
      o_RSP_VALID <= (r_state == HOLD) && (w_state_nxt == IDLE);
      if (w_accept) begin
        r_wr    <= i_REQ_WR;
        o_ZA    <= i_REQ_ADDR;
        o_ZD_OE <= i_REQ_WR;
        if (i_REQ_WR) begin
          o_ZD <= i_REQ_DATA;
        end
      end else if (w_state_nxt == IDLE) begin
        o_ZD_OE <= 1'b0;
      end
      if ((r_state == STROBE) && (w_state_nxt == HOLD) && !r_wr) begin
        o_RSP_DATA <= i_ZD;
      end
    end
  end

endmodule

// File: tb/tb_psa_z80_io_master.sv
module tb_psa_z80_io_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst[2];
  logic       req_valid[2];
  logic       ready[2];
  logic       req_wr[2];
  logic [7:0] req_addr[2];
  logic [7:0] req_data[2];
  logic       rsp_valid[2];
  logic [7:0] rsp_data[2];
  logic       niorq[2];
  logic       nrd[2];
  logic       nwr[2];
  logic [7:0] za[2];
  logic [7:0] zd_o[2];
  logic       zd_oe[2];
  logic [7:0] zd_i[2];
  logic       nwait[2];

  psa_z80_io_master u_dut0 (
    .i_CLK(clk), .i_RST(rst[0]), .i_REQ_VALID(req_valid[0]), .o_REQ_READY(ready[0]),
    .i_REQ_WR(req_wr[0]), .i_REQ_ADDR(req_addr[0]), .i_REQ_DATA(req_data[0]),
    .o_RSP_VALID(rsp_valid[0]), .o_RSP_DATA(rsp_data[0]), .o_nIORQ(niorq[0]),
    .o_nRD(nrd[0]), .o_nWR(nwr[0]), .o_ZA(za[0]), .o_ZD(zd_o[0]),
    .o_ZD_OE(zd_oe[0]), .i_ZD(zd_i[0]), .i_nWAIT(nwait[0])
  );

  psa_z80_io_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) u_dut1 (
    .i_CLK(clk), .i_RST(rst[1]), .i_REQ_VALID(req_valid[1]), .o_REQ_READY(ready[1]),
    .i_REQ_WR(req_wr[1]), .i_REQ_ADDR(req_addr[1]), .i_REQ_DATA(req_data[1]),
    .o_RSP_VALID(rsp_valid[1]), .o_RSP_DATA(rsp_data[1]), .o_nIORQ(niorq[1]),
    .o_nRD(nrd[1]), .o_nWR(nwr[1]), .o_ZA(za[1]), .o_ZD(zd_o[1]),
    .o_ZD_OE(zd_oe[1]), .i_ZD(zd_i[1]), .i_nWAIT(nwait[1])
  );

  typedef struct {
    int         k;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rsp;
    int         slen;
    int         setup;
    int         lat;
    int         gap;
  } txn_t;

  txn_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int k, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%0h exp=%0h", name, k, got, exp);
    end
  endtask

  // Monitor: per-cycle bus observation, compare on each o_RSP_VALID.
  int         slen_c[2];
  int         acc[2];
  int         last_low[2];
  int         s_start[2];
  int         s_gap[2];
  logic [7:0] s_za[2];
  logic [7:0] s_zd[2];
  logic       s_oe[2];
  logic       s_pre[2];
  logic [1:0] s_kind[2];
  logic [7:0] za_prev[2];
  logic [7:0] zd_prev[2];
  logic       oe_prev[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      slen_c[k] = 0; acc[k] = 0; last_low[k] = 0; s_start[k] = 0; s_gap[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        slen_c[k] = 0;
        while (sbq.size() > 0 && sbq[0].k == k) void'(sbq.pop_front());
      end else begin
        chk("rd_wr_exclusive", k, int'(!nrd[k] && !nwr[k]), 0);
        if (!niorq[k]) begin
          if (slen_c[k] == 0) begin
            s_start[k] = cyc;
            s_gap[k]   = cyc - last_low[k] - 1;
            s_za[k]    = za[k];
            s_zd[k]    = zd_o[k];
            s_oe[k]    = zd_oe[k];
            s_kind[k]  = {nwr[k], nrd[k]};
            s_pre[k]   = (za_prev[k] == za[k]) && (zd_prev[k] == zd_o[k]) && (oe_prev[k] == zd_oe[k]);
          end
          slen_c[k]++;
          last_low[k] = cyc;
        end
        if (rsp_valid[k]) begin
          if (sbq.size() == 0 || sbq[0].k != k) begin
            chk("unexpected_rsp", k, 1, 0);
          end else begin
            txn_t e;
            e = sbq.pop_front();
            chk("rsp_data", k, rsp_data[k], e.rsp);
            chk("latency", k, cyc - acc[k], e.lat);
            chk("strobe_len", k, slen_c[k], e.slen);
            chk("setup_len", k, s_start[k] - acc[k], e.setup);
            chk("addr_at_strobe", k, s_za[k], e.addr);
            chk("strobe_kind", k, s_kind[k], e.wr ? 2'b01 : 2'b10);
            chk("oe_at_strobe", k, s_oe[k], e.wr);
            chk("bus_stable_before_strobe", k, s_pre[k], 1);
            if (e.wr) chk("data_at_strobe", k, s_zd[k], e.data);
            if (e.gap >= 0) chk("strobe_gap", k, s_gap[k], e.gap);
          end
          slen_c[k] = 0;
        end
        if (req_valid[k] && ready[k]) acc[k] = cyc + 1;
      end
      za_prev[k] = za[k];
      zd_prev[k] = zd_o[k];
      oe_prev[k] = zd_oe[k];
    end
  end

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic issue(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rsp, input int slen, input int setup, input int lat,
                       input int gap, input bit keep);
    txn_t t;
    int n;
    t.k = k; t.wr = wr; t.addr = a; t.data = d; t.rsp = rsp;
    t.slen = slen; t.setup = setup; t.lat = lat; t.gap = gap;
    sbq.push_back(t);
    req_wr[k] = wr; req_addr[k] = a; req_data[k] = d; req_valid[k] = 1'b1;
    n = 0;
    while (!ready[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", k, n, 0);
    if (gap >= 0) chk("b2b_accept_in_rsp_cycle", k, rsp_valid[k], 1);
    @(posedge clk); #1;
    if (!keep) req_valid[k] = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_wr[k] = 1'b0;
      req_addr[k] = '0; req_data[k] = '0; zd_i[k] = '0; nwait[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, ready[k], 0);
      chk("rst_niorq", k, niorq[k], 1);
      chk("rst_nrd", k, nrd[k], 1);
      chk("rst_nwr", k, nwr[k], 1);
      chk("rst_za", k, za[k], 8'h00);
      chk("rst_zd", k, zd_o[k], 8'h00);
      chk("rst_oe", k, zd_oe[k], 0);
      chk("rst_rsp_valid", k, rsp_valid[k], 0);
      chk("rst_rsp_data", k, rsp_data[k], 8'h00);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 0, ready[0], 1);
    chk("ready_after_release", 1, ready[1], 1);
    @(posedge clk); #1;

    // Write $02 <- $08, defaults.
    issue(0, 1'b1, 8'h02, 8'h08, 8'h00, 2, 1, 4, -1, 1'b0);

    // Read $0C, data present only during the strobe.
    issue(0, 1'b0, 8'h0C, 8'h00, 8'h5A, 2, 1, 4, -1, 1'b0);
    @(posedge clk); #1 zd_i[0] = 8'h5A;
    @(posedge clk);
    @(posedge clk); #1 zd_i[0] = 8'h00;

    // Following write keeps the read data.
    issue(0, 1'b1, 8'h05, 8'h77, 8'h5A, 2, 1, 4, -1, 1'b0);

    // Read $01 with three wait states spanning the last strobe cycle.
    issue(0, 1'b0, 8'h01, 8'h00, 8'h3C, 5, 1, 7, -1, 1'b0);
    zd_i[0] = 8'hC3;
    @(posedge clk);
    @(posedge clk); #1 nwait[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 nwait[0] = 1'b1; zd_i[0] = 8'h3C;
    @(posedge clk); #1 zd_i[0] = 8'h00;

    // Back-to-back writes with i_REQ_VALID held high.
    issue(0, 1'b1, 8'h00, 8'h01, 8'h3C, 2, 1, 4, -1, 1'b1);
    issue(0, 1'b1, 8'h00, 8'h23, 8'h3C, 2, 1, 4, 3, 1'b0);

    // Reset during the first strobe cycle of a write.
    issue(0, 1'b1, 8'h03, 8'hAA, 8'h00, 2, 1, 4, -1, 1'b0);
    @(posedge clk); #1 rst[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_strobe", 0, niorq[0], 0);
    chk("mid_rst_ready_low", 0, ready[0], 0);
    @(posedge clk); #1 rst[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_niorq", 0, niorq[0], 1);
    chk("mid_rst_nwr", 0, nwr[0], 1);
    chk("mid_rst_nrd", 0, nrd[0], 1);
    chk("mid_rst_oe", 0, zd_oe[0], 0);
    chk("mid_rst_ready", 0, ready[0], 1);
    chk("mid_rst_za", 0, za[0], 8'h00);
    chk("mid_rst_rsp_data", 0, rsp_data[0], 8'h00);
    repeat (6) @(posedge clk);
    #1;
    issue(0, 1'b1, 8'h04, 8'h55, 8'h00, 2, 1, 4, -1, 1'b0);

    // SETUP=3, STROBE=1, HOLD=2 instance.
    issue(1, 1'b1, 8'h0F, 8'hC5, 8'h00, 1, 3, 6, -1, 1'b0);
    zd_i[1] = 8'h99;
    issue(1, 1'b0, 8'h0A, 8'h00, 8'h99, 1, 3, 6, -1, 1'b0);

    n = 0;
    while (sbq.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 0, sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
